ins_loader: RTL and testbench

Byte-serial instruction loader: accepts a stream of bytes, packs each group of four into a 32-bit instruction word `{op, v2, v1, v0}`, and writes the words into program memory at consecutive addresses. It is the writer side of the stage-0 instruction resolver. The word layout it produces is exactly the layout stage 0 splits back into `v0`/`v1`/`v2`/`op`. It sits between the boot/host byte link and the program ROM/RAM write port.

---
 rtl/ins_pkg.sv | 21 ++
 rtl/ins_word_packer.sv | 43 ++++
 rtl/ins_loader.sv | 124 ++++++++++++
 tb/tb_ins_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ins_pkg.sv
// Shared instruction-word layout and loader state encoding, used by both the
// loader (packing side) and the stage-0 resolver (splitting side).
package ins_pkg;

    localparam int unsigned INS_WIDTH  = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned INS_LANES  = 4;

    localparam int unsigned INS_V0_LSB = 0;
    localparam int unsigned INS_V1_LSB = 8;
    localparam int unsigned INS_V2_LSB = 16;
    localparam int unsigned INS_OP_LSB = 24;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_EMIT    = 2'd2,
        LD_FULL    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/ins_word_packer.sv
// Four byte-lane registers assembled into one instruction word {op, v2, v1, v0}.
module ins_word_packer
    import ins_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 we,
    input  logic [1:0]           lane,
    input  logic [BYTE_W-1:0]    byte_in,
    output logic [INS_WIDTH-1:0] word
);

    logic [INS_LANES-1:0][BYTE_W-1:0] lane_q;
    logic [INS_LANES-1:0][BYTE_W-1:0] lane_d;

    // Clear wins over a write so a restart never leaves a stale lane behind.
    always_comb begin
        lane_d = lane_q;
        if (clear) begin
            lane_d = '0;
        end else if (we) begin
            lane_d[lane] = byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    always_comb begin
        word = '0;
        word[INS_V0_LSB +: BYTE_W] = lane_q[0];
        word[INS_V1_LSB +: BYTE_W] = lane_q[1];
        word[INS_V2_LSB +: BYTE_W] = lane_q[2];
        word[INS_OP_LSB +: BYTE_W] = lane_q[3];
    end

endmodule

// File: rtl/ins_loader.sv
// Byte-serial instruction loader: packs 4 bytes per word and writes words to
// consecutive program-memory addresses. Optional INS_LOADER_CHECKSUM_EN adds a running byte sum.
module ins_loader
    import ins_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [INS_WIDTH-1:0]  ins_word,
    output logic [ADDR_WIDTH-1:0] ins_addr,
    output logic                  ins_we,
    input  logic                  ins_ack,
    output logic                  busy,
    output logic                  full,
    output logic [BYTE_W-1:0]     checksum
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

    ld_state_e             state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  accept;

    assign in_ready = (state_q == LD_COLLECT) && !start;
    assign busy     = (state_q == LD_COLLECT) || (state_q == LD_EMIT);
    assign full     = (state_q == LD_FULL);
    assign accept   = in_valid && in_ready;

    // Next state; start overrides ack and byte accept in every state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        if (start) begin
            state_d = LD_COLLECT;
            idx_d   = 2'd0;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                LD_COLLECT: begin
                    if (accept) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = LD_EMIT;
                        end
                    end
                end
                LD_EMIT: begin
                    if (ins_ack) begin
                        if (addr_q == ADDR_MAX) begin
                            state_d = LD_FULL;
                        end else begin
                            state_d = LD_COLLECT;
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        we_d = (state_d == LD_EMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_IDLE;
            idx_q   <= 2'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    assign ins_addr = addr_q;
    assign ins_we   = we_q;

    ins_word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .we      (accept),
        .lane    (idx_q),
        .byte_in (in_byte),
        .word    (ins_word)
    );

`ifdef INS_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;

    // Counts every accepted byte, including bytes of a word later abandoned.
    always_comb begin
        csum_d = csum_q;
        if (start) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ins_loader.sv
// Bench for ins_loader (ADDR_WIDTH=2): directed scenarios plus random traffic
// checked against a byte/word level reference model.
module tb_ins_loader;

    localparam int AW   = 2;
    localparam int AMAX = (1 << AW) - 1;
    localparam int M_IDLE = 0, M_COLLECT = 1, M_EMIT = 2, M_FULL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   ins_word;
    logic [AW-1:0] ins_addr;
    logic          ins_we;
    logic          ins_ack;
    logic          busy;
    logic          full;
    logic [7:0]    checksum;

    int total = 0;
    int bad   = 0;

    // reference model
    int         m_mode;
    int         m_cnt;
    int         m_addr;
    int         m_csum;
    logic [7:0] m_lane [4];

    ins_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ins_word (ins_word),
        .ins_addr (ins_addr),
        .ins_we   (ins_we),
        .ins_ack  (ins_ack),
        .busy     (busy),
        .full     (full),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word();
        return {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
    endfunction

    function automatic logic [7:0] m_checksum();
`ifdef INS_LOADER_CHECKSUM_EN
        return 8'(m_csum & 255);
`else
        return 8'h00;
`endif
    endfunction

    task automatic m_clear();
        m_cnt  = 0;
        m_addr = 0;
        m_csum = 0;
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
    endtask

    // One clock: drive at negedge, check decoded outputs, advance model, check registers.
    task automatic cyc(input logic r, input logic st, input logic v, input logic [7:0] b, input logic ack);
        logic exp_rdy;
        logic acc;
        reset = r; start = st; in_valid = v; in_byte = b; ins_ack = ack;
        #1;
        exp_rdy = (m_mode == M_COLLECT) && !st;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'((m_mode == M_COLLECT) || (m_mode == M_EMIT)));
        chk("full", 32'(full), 32'(m_mode == M_FULL));
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            m_mode = M_IDLE;
            m_clear();
        end else if (st) begin
            m_mode = M_COLLECT;
            m_clear();
        end else if (m_mode == M_COLLECT && acc) begin
            m_lane[m_cnt] = b;
            m_csum = (m_csum + int'(b)) % 256;
            m_cnt++;
            if (m_cnt == 4) begin
                m_cnt  = 0;
                m_mode = M_EMIT;
            end
        end else if (m_mode == M_EMIT && ack) begin
            if (m_addr == AMAX) m_mode = M_FULL;
            else begin
                m_addr++;
                m_mode = M_COLLECT;
            end
        end
        @(negedge clk);
        chk("ins_we", 32'(ins_we), 32'(m_mode == M_EMIT));
        chk("ins_addr", 32'(ins_addr), 32'(m_addr));
        chk("ins_word", ins_word, m_word());
        chk("checksum", 32'(checksum), 32'(m_checksum()));
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, w[8*i +: 8], 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; ins_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_mode = M_IDLE;
        m_clear();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_word", ins_word, 32'd0);
        chk("rst_addr", 32'(ins_addr), 32'd0);
        chk("rst_we", 32'(ins_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);

        // basic word with ack already high
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b1);
        chk("t1_we", 32'(ins_we), 32'd1);
        chk("t1_word", ins_word, 32'h44332211);
        chk("t1_addr", 32'(ins_addr), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t1_we_drop", 32'(ins_we), 32'd0);
        chk("t1_next_addr", 32'(ins_addr), 32'd1);

        // stalled write: word/addr held, no bytes taken
        send4(32'h88776655);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
            chk("stall_word", ins_word, 32'h88776655);
            chk("stall_addr", 32'(ins_addr), 32'd1);
            chk("stall_rdy", 32'(in_ready), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        chk("stall_next_addr", 32'(ins_addr), 32'd2);

        // fill to the last address
        send4(32'hA3A2A1A0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        send4(32'hB3B2B1B0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_addr", 32'(ins_addr), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full_word_kept", ins_word, 32'hB3B2B1B0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("restart_addr", 32'(ins_addr), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);

        // start in EMIT together with ack abandons the word
        send4(32'h04030201);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("abandon_we", 32'(ins_we), 32'd0);
        chk("abandon_addr", 32'(ins_addr), 32'd0);
        send4(32'h14131211);
        chk("abandon_next_addr", 32'(ins_addr), 32'd0);
        chk("abandon_next_word", ins_word, 32'h14131211);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // reset mid-word discards partial lanes
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        chk("midrst_busy", 32'(busy), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send4(32'hDDCCBBAA);
        chk("midrst_word", ins_word, 32'hDDCCBBAA);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // checksum wrap
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        send4(32'h010002FF);
`ifdef INS_LOADER_CHECKSUM_EN
        chk("csum_wrap", 32'(checksum), 32'h02);
`else
        chk("csum_off", 32'(checksum), 32'h00);
`endif
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            cyc(1'b0 + 1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 99) < 3),
                1'($urandom_range(0, 9) < 7),
                8'($urandom),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
